// File: rtl/tlp_mwr_axi_wr_if.sv
// Bus bundle for the MWr-to-AXI write bridge: demux write-port TLP stream plus AXI4 AW/W/B.
// The master view belongs to the bridge (AXI master, TLP stream sink).
interface tlp_mwr_axi_wr_if #(
   parameter int DOUBLE_WORD  = 32'd32,
   parameter int HEADER_SIZE  = 32'd4 * DOUBLE_WORD,
   parameter int PAYLOAD_SIZE = 32'd8 * DOUBLE_WORD,
   parameter int ADDR_WIDTH   = 32'd64
);
   logic [PAYLOAD_SIZE-1:0]   in_data;
   logic [HEADER_SIZE-1:0]    in_hdr;
   logic                      in_sop;
   logic                      in_eop;
   logic                      in_valid;
   logic                      in_ready;
   logic [ADDR_WIDTH-1:0]     m_axi_awaddr;
   logic [7:0]                m_axi_awlen;
   logic [2:0]                m_axi_awsize;
   logic [1:0]                m_axi_awburst;
   logic                      m_axi_awvalid;
   logic                      m_axi_awready;
   logic [PAYLOAD_SIZE-1:0]   m_axi_wdata;
   logic [PAYLOAD_SIZE/8-1:0] m_axi_wstrb;
   logic                      m_axi_wlast;
   logic                      m_axi_wvalid;
   logic                      m_axi_wready;
   logic [1:0]                m_axi_bresp;
   logic                      m_axi_bvalid;
   logic                      m_axi_bready;

   modport master (
      input  in_data, in_hdr, in_sop, in_eop, in_valid,
      output in_ready,
      output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid,
      output m_axi_bready
   );

   modport slave (
      output in_data, in_hdr, in_sop, in_eop, in_valid,
      input  in_ready,
      input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready
   );
endinterface

// File: rtl/tlp_mwr_axi_wr.sv
// Turns each MWr TLP into one AXI4 INCR write burst, one TLP in flight at a time.
// Malformed or unsupported TLPs are drained and flagged with single-cycle error pulses.
module tlp_mwr_axi_wr #(
   parameter int DOUBLE_WORD  = 32'd32,
   parameter int HEADER_SIZE  = 32'd4 * DOUBLE_WORD,
   parameter int PAYLOAD_SIZE = 32'd8 * DOUBLE_WORD,
   parameter int ADDR_WIDTH   = 32'd64
) (
   input  logic             clk,
   input  logic             rst_n,
   tlp_mwr_axi_wr_if.master bus,
   input  logic             enable,
   output logic             busy,
   output logic             err_type,
   output logic             err_align,
   output logic             err_len,
   output logic             err_resp
);
   localparam int LANES  = PAYLOAD_SIZE / DOUBLE_WORD;
   localparam int STRB_W = PAYLOAD_SIZE / 32'd8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_AW    = 3'd1;
   localparam logic [2:0] ST_W     = 3'd2;
   localparam logic [2:0] ST_PAD   = 3'd3;
   localparam logic [2:0] ST_B     = 3'd4;
   localparam logic [2:0] ST_DRAIN = 3'd5;

   logic [HEADER_SIZE-1:0]  hdr_s;
   logic [2:0]              state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0]   awaddr_r, addr_s;
   logic [7:0]              awlen_r, awlen_s, beat_cnt_r, beat_cnt_nxt_s;
   logic [10:0]             len_r, len_s, len_m1_s;
   logic [3:0]              fbe_r, lbe_r;
   logic                    drain_r, drain_nxt_s, awvalid_r, bready_r, busy_r;
   logic                    err_type_r, err_align_r, err_len_r, err_resp_r;
   logic                    type_p_s, align_p_s, len_p_s, resp_p_s;
   logic                    start_s, is_mwr_s, aligned_s, last_beat_s, unused_hdr_s;
   logic                    in_ready_s, wvalid_s, wlast_s;
   logic [PAYLOAD_SIZE-1:0] wdata_s;
   logic [STRB_W-1:0]       wstrb_s;

   // DW i of the TLP: 0 -> firstBE, length-1 -> lastBE, beyond length -> none, else all
   function automatic logic [STRB_W-1:0] beat_strb(input logic [7:0] beat, input logic [10:0] len,
                                                   input logic [3:0] fbe, input logic [3:0] lbe);
      logic [STRB_W-1:0] s;
      logic [10:0]       idx;
      s = '0;
      for (int k = 0; k < LANES; k++) begin
         idx = {beat, 3'(k)};
         if (idx >= len)                 s[32'd4*k +: 4] = 4'h0;
         else if (idx == 11'd0)          s[32'd4*k +: 4] = fbe;
         else if (idx == len - 11'd1)    s[32'd4*k +: 4] = lbe;
         else                            s[32'd4*k +: 4] = 4'hF;
      end
      return s;
   endfunction

   assign hdr_s        = bus.in_hdr;
   assign unused_hdr_s = ^{hdr_s[97:96], hdr_s[63:40], hdr_s[31], hdr_s[23:10]};

   // Header field decode; only latched when a new TLP starts in IDLE
   always_comb begin
      if (hdr_s[29]) addr_s = {hdr_s[95:64], hdr_s[127:98], 2'b00};
      else           addr_s = {32'd0, hdr_s[95:66], 2'b00};
      if (hdr_s[9:0] == 10'd0) len_s = 11'd1024;
      else                     len_s = {1'b0, hdr_s[9:0]};
      len_m1_s  = len_s - 11'd1;
      awlen_s   = len_m1_s[10:3];
      is_mwr_s  = hdr_s[30] & (hdr_s[28:24] == 5'd0);
      aligned_s = (addr_s[4:0] == 5'd0);
   end

   assign start_s     = enable & bus.in_valid & bus.in_sop;
   assign last_beat_s = (beat_cnt_r == awlen_r);

   // Next-state, W-channel pass-through and error-pulse generation
   always_comb begin
      state_nxt_s    = state_r;
      beat_cnt_nxt_s = beat_cnt_r;
      drain_nxt_s    = drain_r;
      in_ready_s     = 1'b0;
      wvalid_s       = 1'b0;
      wdata_s        = '0;
      wstrb_s        = '0;
      wlast_s        = 1'b0;
      type_p_s       = 1'b0;
      align_p_s      = 1'b0;
      len_p_s        = 1'b0;
      resp_p_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               beat_cnt_nxt_s = 8'd0;
               drain_nxt_s    = 1'b0;
               if (!is_mwr_s) begin
                  type_p_s    = 1'b1;
                  state_nxt_s = ST_DRAIN;
               end else if (!aligned_s) begin
                  align_p_s   = 1'b1;
                  state_nxt_s = ST_DRAIN;
               end else begin
                  state_nxt_s = ST_AW;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_AW: begin
            if (bus.m_axi_awready) state_nxt_s = ST_W;
            else                   state_nxt_s = ST_AW;
         end
         ST_W: begin
            in_ready_s = bus.m_axi_wready;
            wvalid_s   = bus.in_valid;
            wdata_s    = bus.in_data;
            wstrb_s    = beat_strb(beat_cnt_r, len_r, fbe_r, lbe_r);
            wlast_s    = last_beat_s;
            if (bus.in_valid & bus.m_axi_wready) begin
               beat_cnt_nxt_s = beat_cnt_r + 8'd1;
               if (last_beat_s) begin
                  state_nxt_s = ST_B;
                  if (!bus.in_eop) begin
                     len_p_s     = 1'b1;
                     drain_nxt_s = 1'b1;
                  end else begin
                     drain_nxt_s = 1'b0;
                  end
               end else if (bus.in_eop) begin
                  len_p_s     = 1'b1;
                  state_nxt_s = ST_PAD;
               end else begin
                  state_nxt_s = ST_W;
               end
            end else begin
               state_nxt_s = ST_W;
            end
         end
         ST_PAD: begin
            wvalid_s = 1'b1;
            wlast_s  = last_beat_s;
            if (bus.m_axi_wready) begin
               beat_cnt_nxt_s = beat_cnt_r + 8'd1;
               if (last_beat_s) state_nxt_s = ST_B;
               else             state_nxt_s = ST_PAD;
            end else begin
               state_nxt_s = ST_PAD;
            end
         end
         ST_B: begin
            if (bus.m_axi_bvalid) begin
               resp_p_s = (bus.m_axi_bresp != 2'b00);
               if (drain_r) state_nxt_s = ST_DRAIN;
               else         state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_B;
            end
         end
         ST_DRAIN: begin
            in_ready_s = 1'b1;
            if (bus.in_valid & bus.in_eop) state_nxt_s = ST_IDLE;
            else                           state_nxt_s = ST_DRAIN;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, burst descriptor and registered control/error outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         awaddr_r    <= '0;
         awlen_r     <= 8'd0;
         len_r       <= 11'd0;
         fbe_r       <= 4'd0;
         lbe_r       <= 4'd0;
         beat_cnt_r  <= 8'd0;
         drain_r     <= 1'b0;
         awvalid_r   <= 1'b0;
         bready_r    <= 1'b0;
         busy_r      <= 1'b0;
         err_type_r  <= 1'b0;
         err_align_r <= 1'b0;
         err_len_r   <= 1'b0;
         err_resp_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         beat_cnt_r  <= beat_cnt_nxt_s;
         drain_r     <= drain_nxt_s;
         awvalid_r   <= (state_nxt_s == ST_AW);
         bready_r    <= (state_nxt_s == ST_B);
         busy_r      <= (state_nxt_s != ST_IDLE);
         err_type_r  <= type_p_s;
         err_align_r <= align_p_s;
         err_len_r   <= len_p_s;
         err_resp_r  <= resp_p_s;
         if ((state_r == ST_IDLE) && start_s) begin
            awaddr_r <= addr_s;
            awlen_r  <= awlen_s;
            len_r    <= len_s;
            fbe_r    <= hdr_s[35:32];
            lbe_r    <= hdr_s[39:36];
         end else begin
            awaddr_r <= awaddr_r;
            awlen_r  <= awlen_r;
            len_r    <= len_r;
            fbe_r    <= fbe_r;
            lbe_r    <= lbe_r;
         end
      end
   end

   assign bus.in_ready      = in_ready_s;
   assign bus.m_axi_awaddr  = awaddr_r;
   assign bus.m_axi_awlen   = awlen_r;
   assign bus.m_axi_awsize  = 3'd5;
   assign bus.m_axi_awburst = 2'b01;
   assign bus.m_axi_awvalid = awvalid_r;
   assign bus.m_axi_wdata   = wdata_s;
   assign bus.m_axi_wstrb   = wstrb_s;
   assign bus.m_axi_wlast   = wlast_s;
   assign bus.m_axi_wvalid  = wvalid_s;
   assign bus.m_axi_bready  = bready_r;
   assign busy              = busy_r;
   assign err_type          = err_type_r;
   assign err_align         = err_align_r;
   assign err_len           = err_len_r;
   assign err_resp          = err_resp_r;
endmodule

// File: tb/tb_tlp_mwr_axi_wr.sv
// Randomized bench for tlp_mwr_axi_wr: a per-TLP expectation model feeds AW/W/error
// queues that a single negedge compare process checks against the DUT.
module tb_tlp_mwr_axi_wr;
   logic clk = 1'b0;
   logic rst_n;
   logic enable, busy, err_type, err_align, err_len, err_resp;

   always #5 clk = ~clk;

   tlp_mwr_axi_wr_if bus ();

   tlp_mwr_axi_wr dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .enable(enable), .busy(busy),
      .err_type(err_type), .err_align(err_align), .err_len(err_len), .err_resp(err_resp)
   );

   typedef struct {logic [63:0] addr; logic [7:0] len;} aw_t;
   typedef struct {logic [255:0] data; logic [31:0] strb; logic last;} w_t;

   aw_t        exp_aw[$];
   w_t         exp_w[$];
   int         exp_err[$];
   logic [1:0] bresp_q[$];
   int         errors = 0;
   int         checks = 0;
   int         b_pend = 0;
   int         stall_cnt = 0;
   logic       pad_hold = 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int model_len(input logic [9:0] l);
      return (l == 10'd0) ? 1024 : int'(l);
   endfunction

   function automatic int model_beats(input logic [9:0] l);
      return (model_len(l) + 7) / 8;
   endfunction

   // Byte enables for one 8-DW beat, from the per-DW enable list of the whole TLP
   function automatic logic [31:0] model_strb(input int len, input int beat,
                                              input logic [3:0] fbe, input logic [3:0] lbe);
      logic [3:0]  dw_be[$];
      logic [31:0] s;
      int          idx;
      for (int i = 0; i < len; i++) begin
         if (i == 0)            dw_be.push_back(fbe);
         else if (i == len - 1) dw_be.push_back(lbe);
         else                   dw_be.push_back(4'hF);
      end
      s = 32'd0;
      for (int k = 0; k < 8; k++) begin
         idx = beat * 8 + k;
         if (idx < len) s[k*4 +: 4] = dw_be[idx];
      end
      return s;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [127:0] mk_hdr(input logic [2:0] fmt, input logic [4:0] typ,
                                           input logic [9:0] len, input logic [3:0] fbe,
                                           input logic [3:0] lbe, input logic [63:0] addr);
      logic [127:0] h;
      h[31:0]  = {fmt, typ, 14'd0, len};
      h[63:32] = {24'd0, lbe, fbe};
      if (fmt[0]) begin
         h[95:64]  = addr[63:32];
         h[127:96] = addr[31:0];
      end else begin
         h[95:64]  = addr[31:0];
         h[127:96] = $urandom;
      end
      return h;
   endfunction

   // Queue the expected outcome of one TLP, then drive its n_in beats
   task automatic send_tlp(input logic [2:0] fmt, input logic [4:0] typ, input logic [9:0] len,
                           input logic [3:0] fbe, input logic [3:0] lbe, input logic [63:0] addr,
                           input int n_in, input logic [1:0] bresp);
      logic [255:0] d[$];
      logic [127:0] h;
      logic [63:0]  ea;
      int           nl, nb, t;
      logic         acc;
      w_t           wb;
      for (int j = 0; j < n_in; j++) d.push_back(rand256());
      h  = mk_hdr(fmt, typ, len, fbe, lbe, addr);
      ea = fmt[0] ? {addr[63:2], 2'b00} : {32'd0, addr[31:2], 2'b00};
      nl = model_len(len);
      nb = model_beats(len);
      if (!(fmt[1] && typ == 5'd0)) exp_err.push_back(1);
      else if (ea[4:0] != 5'd0)     exp_err.push_back(2);
      else begin
         exp_aw.push_back('{ea, 8'(nb - 1)});
         for (int j = 0; j < nb; j++) begin
            if (j < n_in) wb = '{d[j], model_strb(nl, j, fbe, lbe), j == nb - 1};
            else          wb = '{256'd0, 32'd0, j == nb - 1};
            exp_w.push_back(wb);
         end
         if (n_in != nb) exp_err.push_back(3);
         bresp_q.push_back(bresp);
         if (bresp != 2'b00) exp_err.push_back(4);
      end
      for (int j = 0; j < n_in; j++) begin
         if ($urandom % 4 == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
         end
         bus.in_valid = 1'b1;
         bus.in_sop   = (j == 0);
         bus.in_eop   = (j == n_in - 1);
         bus.in_data  = d[j];
         bus.in_hdr   = (j == 0) ? h : {$urandom, $urandom, $urandom, $urandom};
         t = 0;
         do begin
            @(negedge clk);
            acc = bus.in_valid & bus.in_ready;
            @(posedge clk); #1;
            t++;
         end while (!acc && t < 3000);
         if (!acc) begin
            check("beat_accept_timeout", 1'b0, 1'b1);
            break;
         end
      end
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
   endtask

   task automatic wait_idle();
      int t, quiet;
      t = 0;
      quiet = 0;
      while (quiet < 3 && t < 6000) begin
         @(posedge clk); #3;
         if (!busy) quiet++;
         else       quiet = 0;
         t++;
      end
      check("idle_timeout", quiet >= 3, 1'b1);
      check("aw_outstanding", exp_aw.size(), 0);
      check("w_outstanding", exp_w.size(), 0);
      check("err_outstanding", exp_err.size(), 0);
   endtask

   // AXI slave: random ready, stalls on request, B responses in issue order
   initial begin
      logic bdone, wl;
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      bus.m_axi_bvalid  = 1'b0;
      bus.m_axi_bresp   = 2'b00;
      forever begin
         @(negedge clk);
         bdone = bus.m_axi_bvalid & bus.m_axi_bready;
         wl    = bus.m_axi_wvalid & bus.m_axi_wready & bus.m_axi_wlast;
         @(posedge clk); #2;
         if (!rst_n) begin
            bus.m_axi_bvalid = 1'b0;
            b_pend = 0;
            bresp_q.delete();
         end else begin
            if (bdone) bus.m_axi_bvalid = 1'b0;
            if (wl) b_pend++;
            bus.m_axi_awready = ($urandom % 3 != 0);
            if (stall_cnt > 0) begin
               bus.m_axi_wready = 1'b0;
               stall_cnt--;
            end else if (pad_hold && bus.m_axi_wvalid && !bus.in_valid) begin
               bus.m_axi_wready = 1'b0;
            end else begin
               bus.m_axi_wready = ($urandom % 4 != 0);
            end
            if (!bus.m_axi_bvalid && b_pend > 0 && ($urandom % 2 == 1) && bresp_q.size() > 0) begin
               bus.m_axi_bvalid = 1'b1;
               bus.m_axi_bresp  = bresp_q.pop_front();
               b_pend--;
            end
         end
      end
   end

   // Compare process: every handshake and error pulse against the model queues
   always @(negedge clk) begin
      aw_t a;
      w_t  w;
      int  n, code;
      if (!rst_n) begin
         exp_aw.delete();
         exp_w.delete();
         exp_err.delete();
      end else begin
         if (bus.m_axi_awvalid && bus.m_axi_awready) begin
            if (exp_aw.size() == 0) check("aw_unexpected", 1'b1, 1'b0);
            else begin
               a = exp_aw.pop_front();
               check("awaddr", bus.m_axi_awaddr, a.addr);
               check("awlen", bus.m_axi_awlen, a.len);
               check("awsize", bus.m_axi_awsize, 3'd5);
               check("awburst", bus.m_axi_awburst, 2'b01);
            end
         end
         if (bus.m_axi_wvalid && bus.m_axi_wready) begin
            if (exp_w.size() == 0) check("w_unexpected", 1'b1, 1'b0);
            else begin
               w = exp_w.pop_front();
               check("wdata", bus.m_axi_wdata, w.data);
               check("wstrb", bus.m_axi_wstrb, w.strb);
               check("wlast", bus.m_axi_wlast, w.last);
            end
         end
         if (bus.m_axi_wvalid && !bus.m_axi_wready) check("in_ready_while_wready_low", bus.in_ready, 1'b0);
         n = int'(err_type) + int'(err_align) + int'(err_len) + int'(err_resp);
         if (n > 0) begin
            code = err_type ? 1 : err_align ? 2 : err_len ? 3 : 4;
            if (n > 1) check("err_multiple", n, 1);
            if (exp_err.size() == 0) check("err_unexpected", code, 0);
            else check("err_code", code, exp_err.pop_front());
         end
      end
   end

   initial begin
      logic [2:0]  fmt;
      logic [4:0]  typ;
      logic [9:0]  len;
      logic [63:0] addr;
      int          kind, nb, n_in, t;
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
      bus.in_data  = '0;
      bus.in_hdr   = '0;
      enable       = 1'b1;
      rst_n        = 1'b1;
      #1 rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_awvalid", bus.m_axi_awvalid, 1'b0);
      check("rst_wvalid", bus.m_axi_wvalid, 1'b0);
      check("rst_wlast", bus.m_axi_wlast, 1'b0);
      check("rst_bready", bus.m_axi_bready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_errs", {err_type, err_align, err_len, err_resp}, 4'd0);
      check("rst_awaddr", bus.m_axi_awaddr, 64'd0);
      check("rst_awlen", bus.m_axi_awlen, 8'd0);
      check("rst_wstrb", bus.m_axi_wstrb, 32'd0);
      @(posedge clk); #3 rst_n = 1'b1;

      check("model_strb_len3", model_strb(3, 0, 4'hF, 4'h3), 32'h0000_03FF);
      check("model_strb_len20_b0", model_strb(20, 0, 4'hC, 4'hF), 32'hFFFF_FFFC);
      check("model_strb_len20_b2", model_strb(20, 2, 4'hC, 4'hF), 32'h0000_FFFF);
      check("model_strb_len1", model_strb(1, 0, 4'h5, 4'hA), 32'h0000_0005);
      check("model_beats_len0", model_beats(10'd0), 128);
      check("model_beats_len9", model_beats(10'd9), 2);

      send_tlp(3'b010, 5'd0, 10'd3, 4'hF, 4'h3, 64'h1000, 1, 2'b00);
      wait_idle();
      fork
         send_tlp(3'b011, 5'd0, 10'd20, 4'hC, 4'hF, 64'h1_0000_0040, 3, 2'b00);
         begin
            t = 0;
            do begin @(negedge clk); t++; end
            while (!(bus.m_axi_wvalid && bus.m_axi_wready) && t < 500);
            check("stall_trigger_timeout", t < 500, 1'b1);
            @(posedge clk); #1 stall_cnt = 3;
         end
      join
      wait_idle();
      send_tlp(3'b010, 5'd0, 10'd8, 4'hF, 4'hF, 64'h1004, 2, 2'b00);
      wait_idle();
      send_tlp(3'b000, 5'd0, 10'd4, 4'hF, 4'hF, 64'h2000, 1, 2'b00);
      wait_idle();
      send_tlp(3'b010, 5'd0, 10'd16, 4'hF, 4'hF, 64'h3000, 1, 2'b00);
      wait_idle();
      send_tlp(3'b010, 5'd0, 10'd8, 4'hF, 4'hF, 64'h3100, 2, 2'b00);
      wait_idle();
      send_tlp(3'b010, 5'd0, 10'd5, 4'hF, 4'hF, 64'h4000, 1, 2'b10);
      wait_idle();
      send_tlp(3'b011, 5'd0, 10'd0, 4'hF, 4'hF, 64'h2_0000_0000, 128, 2'b00);
      wait_idle();

      enable = 1'b0;
      fork
         send_tlp(3'b010, 5'd0, 10'd4, 4'hF, 4'hF, 64'h5000, 1, 2'b00);
         begin
            repeat (10) begin
               @(negedge clk);
               check("dis_busy", busy, 1'b0);
               check("dis_in_ready", bus.in_ready, 1'b0);
            end
            enable = 1'b1;
         end
      join
      wait_idle();

      for (int n = 0; n < 40; n++) begin
         kind = $urandom % 10;
         len  = 10'($urandom_range(1, 40));
         fmt  = {2'b01, 1'($urandom % 2)};
         typ  = 5'd0;
         addr = {($urandom % 4 == 0) ? $urandom : 32'd0, $urandom};
         addr[4:2] = 3'd0;
         if (!fmt[0]) addr[63:32] = 32'd0;
         nb   = model_beats(len);
         n_in = nb;
         case (kind)
            0: begin
               if ($urandom % 2 == 1) typ = 5'($urandom_range(1, 31));
               else fmt[1] = 1'b0;
               n_in = $urandom_range(1, 3);
            end
            1: begin
               addr[4:2] = 3'($urandom_range(1, 7));
               n_in = $urandom_range(1, 3);
            end
            2: if (nb > 1) n_in = $urandom_range(1, nb - 1);
            3: n_in = nb + $urandom_range(1, 2);
            default: n_in = nb;
         endcase
         send_tlp(fmt, typ, len, 4'($urandom), 4'($urandom), addr, n_in,
                  ($urandom % 4 == 0) ? 2'b10 : 2'b00);
      end
      wait_idle();

      pad_hold = 1'b1;
      send_tlp(3'b010, 5'd0, 10'd16, 4'hF, 4'hF, 64'h6000, 1, 2'b00);
      t = 0;
      do begin @(negedge clk); t++; end
      while (!(bus.m_axi_wvalid && !bus.in_valid && busy) && t < 200);
      check("pad_reach_timeout", t < 200, 1'b1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      check("rstpad_awvalid", bus.m_axi_awvalid, 1'b0);
      check("rstpad_wvalid", bus.m_axi_wvalid, 1'b0);
      check("rstpad_wlast", bus.m_axi_wlast, 1'b0);
      check("rstpad_bready", bus.m_axi_bready, 1'b0);
      check("rstpad_in_ready", bus.in_ready, 1'b0);
      check("rstpad_busy", busy, 1'b0);
      check("rstpad_errs", {err_type, err_align, err_len, err_resp}, 4'd0);
      repeat (2) @(posedge clk);
      pad_hold = 1'b0;
      #3 rst_n = 1'b1;
      send_tlp(3'b011, 5'd0, 10'd12, 4'h3, 4'h7, 64'h7_0000_0020, 2, 2'b00);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
